// File: rtl/cal_pkg.sv
// Shared types and date arithmetic helpers for the calendar date editor.
package cal_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_Y = 2'd1,
    EDIT_M = 2'd2,
    EDIT_D = 2'd3
  } cal_state_e;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  function automatic logic is_leap(input logic [31:0] y);
    return ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
  endfunction

  // Sakamoto: 0=Sun..6=Sat; Jan/Feb count as belonging to the previous year.
  function automatic logic [2:0] dow(input logic [31:0] y, input logic [31:0] m,
                                     input logic [31:0] d);
    logic [31:0] yy;
    logic [31:0] t;
    logic [31:0] s;
    yy = (m < 32'd3) ? y - 32'd1 : y;
    case (m)
      32'd1:   t = 32'd0;
      32'd2:   t = 32'd3;
      32'd3:   t = 32'd2;
      32'd4:   t = 32'd5;
      32'd5:   t = 32'd0;
      32'd6:   t = 32'd3;
      32'd7:   t = 32'd5;
      32'd8:   t = 32'd1;
      32'd9:   t = 32'd4;
      32'd10:  t = 32'd6;
      32'd11:  t = 32'd2;
      32'd12:  t = 32'd4;
      default: t = 32'd0;
    endcase
    s = yy + yy / 32'd4 - yy / 32'd100 + yy / 32'd400 + t + d;
    return 3'(s % 32'd7);
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Number of days in a month given the month and the leap status of its year.
module cal_month_len
  import cal_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] days
);

  always_comb begin
    case (month)
      FEB:                days = leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: days = 5'd30;
      default:            days = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_date_editor.sv
// Gregorian date keeper advanced by day_tick, with a year/month/day edit mode
// driven by mode/up/down buttons.
module calendar_date_editor
  import cal_pkg::*;
#(
  parameter int YEAR_W       = 14,
  parameter int YEAR_MIN     = 2000,
  parameter int YEAR_MAX     = 9999,
  parameter int RESET_YEAR   = 2025,
  parameter int TICK_IN_EDIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              day_tick,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [2:0]        weekday,
  output logic              leap,
  output logic [1:0]        edit_field,
  output logic              year_wrap
);

  localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_RESET = YEAR_W'(RESET_YEAR);

  logic mode_q, up_q, down_q;
  logic mode_edge, up_edge, down_edge;
  cal_state_e state, state_next;

  logic [YEAR_W-1:0] edit_year, year_n;
  logic [3:0]        edit_month, month_n;
  logic [4:0]        day_n, max_days, clamp_days;
  logic              edit_leap, wrap_n, tick_ok, adjust;

  // Edge registers start high so a button held through reset does not fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b1;
      up_q   <= 1'b1;
      down_q <= 1'b1;
    end else begin
      mode_q <= btn_mode;
      up_q   <= btn_up;
      down_q <= btn_down;
    end
  end

  assign mode_edge = btn_mode & ~mode_q;
  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_edge) state_next = cal_state_e'(state + 2'd1);
  end

  always_comb begin
    edit_field = state;
  end

  assign leap = is_leap(32'(year));

  // Candidate year/month after a +/-1 edit; feeds the clamp month length.
  always_comb begin
    edit_year  = year;
    edit_month = month;
    if (state == EDIT_Y) begin
      if (up_edge) edit_year = (year == Y_MAX) ? Y_MIN : year + YEAR_W'(1);
      else         edit_year = (year == Y_MIN) ? Y_MAX : year - YEAR_W'(1);
    end
    if (state == EDIT_M) begin
      if (up_edge) edit_month = (month == DEC) ? JAN : month + 4'd1;
      else         edit_month = (month == JAN) ? DEC : month - 4'd1;
    end
    edit_leap = is_leap(32'(edit_year));
  end

  cal_month_len u_len_cur   (.month(month),      .leap(leap),      .days(max_days));
  cal_month_len u_len_clamp (.month(edit_month), .leap(edit_leap), .days(clamp_days));

  assign tick_ok = day_tick && ((state == RUN) || (TICK_IN_EDIT != 0));
  assign adjust  = !mode_edge && (state != RUN) && (up_edge ^ down_edge);

  always_comb begin
    year_n  = year;
    month_n = month;
    day_n   = day;
    wrap_n  = 1'b0;
    if (adjust) begin
      case (state)
        EDIT_Y, EDIT_M: begin
          year_n  = edit_year;
          month_n = edit_month;
          day_n   = (day > clamp_days) ? clamp_days : day;
        end
        EDIT_D: begin
          if (up_edge) day_n = (day == max_days) ? 5'd1 : day + 5'd1;
          else         day_n = (day == 5'd1) ? max_days : day - 5'd1;
        end
        default: ;
      endcase
    end else if (tick_ok) begin
      if (day == max_days) begin
        day_n = 5'd1;
        if (month == DEC) begin
          month_n = JAN;
          if (year == Y_MAX) begin
            year_n = Y_MIN;
            wrap_n = 1'b1;
          end else begin
            year_n = year + YEAR_W'(1);
          end
        end else begin
          month_n = month + 4'd1;
        end
      end else begin
        day_n = day + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      year      <= Y_RESET;
      month     <= JAN;
      day       <= 5'd1;
      weekday   <= dow(32'(RESET_YEAR), 32'd1, 32'd1);
      year_wrap <= 1'b0;
    end else begin
      year      <= year_n;
      month     <= month_n;
      day       <= day_n;
      weekday   <= dow(32'(year_n), 32'(month_n), 32'(day_n));
      year_wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_calendar_date_editor.sv
// Randomised and directed scoreboard bench for calendar_date_editor.
module tb_calendar_date_editor;

  localparam int YEAR_W       = 14;
  localparam int YEAR_MIN     = 2000;
  localparam int YEAR_MAX     = 9999;
  localparam int RESET_YEAR   = 2025;
  localparam int TICK_IN_EDIT = 0;
  localparam int VW           = YEAR_W + 4 + 5 + 3 + 1 + 2 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              day_tick = 1'b0;
  logic              btn_mode = 1'b0;
  logic              btn_up = 1'b0;
  logic              btn_down = 1'b0;
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [2:0]        weekday;
  logic              leap;
  logic [1:0]        edit_field;
  logic              year_wrap;

  calendar_date_editor #(
    .YEAR_W(YEAR_W), .YEAR_MIN(YEAR_MIN), .YEAR_MAX(YEAR_MAX),
    .RESET_YEAR(RESET_YEAR), .TICK_IN_EDIT(TICK_IN_EDIT)
  ) dut (
    .clk(clk), .reset(reset), .day_tick(day_tick), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .year(year), .month(month),
    .day(day), .weekday(weekday), .leap(leap), .edit_field(edit_field),
    .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int my, mm, md, mst, mwrap;
  bit pm, pu, pd;
  logic [VW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic bit m_leap(input int y);
    if (y % 400 == 0) return 1'b1;
    if (y % 100 == 0) return 1'b0;
    return (y % 4 == 0);
  endfunction

  function automatic int m_dim(input int y, input int m);
    if (m == 2) return m_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Zeller's congruence (h: 0=Sat), remapped to 0=Sun.
  function automatic int m_weekday(input int y, input int m, input int d);
    int mz, yz, k, j, h;
    mz = (m < 3) ? m + 12 : m;
    yz = (m < 3) ? y - 1 : y;
    k = yz % 100;
    j = yz / 100;
    h = (d + (13 * (mz + 1)) / 5 + k + k / 4 + j / 4 + 5 * j) % 7;
    return (h + 6) % 7;
  endfunction

  function automatic logic [VW-1:0] pack(input int y, input int m, input int d,
                                         input int wd, input bit lp, input int ef,
                                         input bit yw);
    return {YEAR_W'(y), 4'(m), 5'(d), 3'(wd), lp, 2'(ef), yw};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return pack(my, mm, md, m_weekday(my, mm, md), m_leap(my), mst, mwrap[0]);
  endfunction

  task automatic model_reset();
    my = RESET_YEAR; mm = 1; md = 1; mst = 0; mwrap = 0;
    pm = 1'b1; pu = 1'b1; pd = 1'b1;
  endtask

  task automatic model_step(input bit mo, input bit up, input bit dn, input bit tk);
    bit me, ue, de;
    int step, span;
    me = mo && !pm; ue = up && !pu; de = dn && !pd;
    pm = mo; pu = up; pd = dn;
    mwrap = 0;
    span = YEAR_MAX - YEAR_MIN + 1;
    if (!me && mst != 0 && (ue != de)) begin
      step = ue ? 1 : -1;
      if (mst == 1) my = YEAR_MIN + ((my - YEAR_MIN + step + span) % span);
      else if (mst == 2) mm = 1 + ((mm - 1 + step + 12) % 12);
      else md = 1 + ((md - 1 + step + m_dim(my, mm)) % m_dim(my, mm));
      if (md > m_dim(my, mm)) md = m_dim(my, mm);
    end else if (tk && (mst == 0 || TICK_IN_EDIT != 0)) begin
      md++;
      if (md > m_dim(my, mm)) begin
        md = 1; mm++;
        if (mm > 12) begin
          mm = 1; my++;
          if (my > YEAR_MAX) begin
            my = YEAR_MIN;
            mwrap = 1;
          end
        end
      end
    end
    if (me) mst = (mst + 1) % 4;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit mo, input bit up, input bit dn, input bit tk);
    @(negedge clk);
    reset = 1'b0;
    btn_mode = mo; btn_up = up; btn_down = dn; day_tick = tk;
    model_step(mo, up, dn, tk);
    exp_q.push_back(model_vec());
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0);
  endtask

  task automatic press_mode();
    cycle(1, 0, 0, 0); idle();
  endtask

  task automatic press_up();
    cycle(0, 1, 0, 0); idle();
  endtask

  task automatic press_down();
    cycle(0, 0, 1, 0); idle();
  endtask

  task automatic tick();
    cycle(0, 0, 0, 1); idle();
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {year, month, day, weekday, leap, edit_field, year_wrap};
  endfunction

  task automatic report(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got y=%0d m=%0d d=%0d wd=%0d lp=%0d ef=%0d yw=%0d required y=%0d m=%0d d=%0d wd=%0d lp=%0d ef=%0d yw=%0d",
               name, got[VW-1-:YEAR_W], got[15:12], got[11:7], got[6:4], got[3], got[2:1], got[0],
               want[VW-1-:YEAR_W], want[15:12], want[11:7], want[6:4], want[3], want[2:1], want[0]);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        report("date_state", dut_vec(), e);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 report("reset_state", dut_vec(), model_vec());

    // 2024-02-28 -> 02-29 -> 03-01
    press_mode(); press_down(); press_mode(); press_up(); press_mode();
    press_down(); press_down(); press_mode();
    tick(); tick();

    // 2025-02-28 -> 03-01
    press_mode(); press_up(); press_mode(); press_down(); press_mode();
    press_down(); press_mode();
    tick();

    // Build 2025-01-31, then month edit clamps to Feb 28; day wraps 1 <-> 28
    press_mode(); press_mode(); press_down(); press_down(); press_mode();
    press_down(); press_mode();
    press_mode(); press_mode(); press_up();
    press_mode(); press_up(); press_down(); press_mode();

    // 2024-02-29 then year up clamps to 2025-02-28
    press_mode(); press_down(); press_mode(); press_mode(); press_up(); press_mode();
    press_mode(); press_up();
    cycle(0, 1, 1, 0); idle();
    repeat (4) cycle(0, 1, 0, 0);
    idle(); press_down();

    // Mode wins over up; ticks dropped in edit; tick with mode edge in RUN
    cycle(1, 1, 0, 0); idle();
    press_mode();
    tick();
    cycle(1, 0, 0, 1); idle();
    cycle(1, 0, 0, 1); idle();
    press_up();

    // Async reset mid-edit with up held through it
    @(negedge clk);
    reset = 1'b1; btn_up = 1'b1; btn_mode = 1'b0; btn_down = 1'b0; day_tick = 1'b0;
    model_reset();
    #1 report("reset_mid_edit", dut_vec(), model_vec());
    cycle(0, 1, 0, 0); idle();

    // YEAR_MAX-12-31 -> YEAR_MIN-01-01 wrap
    press_mode();
    repeat (RESET_YEAR - YEAR_MIN + 1) press_down();
    press_mode(); press_down(); press_mode(); press_down(); press_mode();
    tick(); idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    idle();

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
